// File: rtl/adc_sample_buffer.sv
// ADC sample buffer: justifies raw SPI ADC words to Q1.23, decimates,
// and queues results in a show-ahead FIFO for the equalizer chain.
module adc_sample_buffer #(
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = 5
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESET,
    input  logic [4:0]         cfg_num_bits,
    input  logic               cfg_offset_binary,
    input  logic [3:0]         cfg_decim,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [23:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [23:0]        out_data,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [3:0]         dec_q, dec_d;
    logic               stg_vld_q, stg_vld_d;
    logic [23:0]        stg_data_q, stg_data_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               ovf_q, ovf_d;
    logic [23:0]        mem [DEPTH];

    logic [4:0]  n_eff;
    logic [4:0]  shamt;
    logic [23:0] fmt_data;
    logic        keep;
    logic        full;
    logic        pop;
    logic        push;

    // Sample formatting: mask to N valid bits, left-justify, optional MSB flip.
    always_comb begin
        n_eff    = cfg_num_bits;
        if (cfg_num_bits == 5'd0 || cfg_num_bits > 5'd24) begin
            n_eff = 5'd24;
        end
        shamt    = 5'd24 - n_eff;
        fmt_data = (in_data & (24'hFF_FFFF >> shamt)) << shamt;
        fmt_data[23] = fmt_data[23] ^ cfg_offset_binary;
    end

    // Output handshake: the head transfers on a cycle where out_valid and
    // out_ready are both high; out_ready with an empty FIFO does nothing.
    assign full      = (level_q == LEVEL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = stg_vld_q && (!full || pop);
    assign keep      = in_valid && (dec_q == 4'd0);

    always_comb begin
        dec_d      = dec_q;
        stg_vld_d  = keep;
        stg_data_d = stg_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        if (clear) begin
            dec_d     = 4'd0;
            stg_vld_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            ovf_d     = 1'b0;
        end else begin
            if (in_valid) begin
                dec_d = (dec_q >= cfg_decim) ? 4'd0 : dec_q + 4'd1;
            end
            if (keep) begin
                stg_data_d = fmt_data;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !push) begin
                level_d = level_q - 1'b1;
            end
            // A staged sample that finds the FIFO full and not draining is lost.
            if (stg_vld_q && full && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            dec_q      <= 4'd0;
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            dec_q      <= dec_d;
            stg_vld_q  <= stg_vld_d;
            stg_data_q <= stg_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push && !clear) begin
            mem[wr_ptr_q] <= stg_data_q;
        end
    end

    // Storage is not reset; gating keeps out_data at zero while empty.
    assign out_data   = out_valid ? mem[rd_ptr_q] : 24'd0;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Self-checking bench for adc_sample_buffer: scenario tasks plus an
// expected-data queue filled at stimulus time and drained against the DUT.
module tb_adc_sample_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  cfg_num_bits = 5'd24;
    logic        cfg_offset_binary = 1'b0;
    logic [3:0]  cfg_decim = 4'd0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = 24'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
    logic [4:0]  fifo_level;
    logic        overflow;

    int          tests_run = 0;
    int          fails = 0;
    int          tb_cnt = 0;
    logic [23:0] exp_q[$];

    adc_sample_buffer #(.DEPTH(16), .LEVEL_W(5)) dut (
        .S_AXI_ACLK        (clk),
        .S_AXI_ARESET      (rst),
        .cfg_num_bits      (cfg_num_bits),
        .cfg_offset_binary (cfg_offset_binary),
        .cfg_decim         (cfg_decim),
        .clear             (clear),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .fifo_level        (fifo_level),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    // Bit-by-bit reference for the justification rules.
    function automatic logic [23:0] model_fmt(input logic [23:0] d, input logic [4:0] nb,
                                              input logic ob);
        int n;
        logic [23:0] r;
        n = (nb == 5'd0 || nb > 5'd24) ? 24 : int'(nb);
        r = 24'd0;
        for (int i = 0; i < n; i++) r[24 - n + i] = d[i];
        if (ob) r[23] = ~r[23];
        return r;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] d);
        in_valid = 1'b1;
        in_data  = d;
        if (tb_cnt == 0) exp_q.push_back(model_fmt(d, cfg_num_bits, cfg_offset_binary));
        tb_cnt = (tb_cnt >= int'(cfg_decim)) ? 0 : tb_cnt + 1;
        step(1);
        in_valid = 1'b0;
        in_data  = 24'd0;
    endtask

    task automatic pulse_clear(input logic with_strobe);
        clear    = 1'b1;
        in_valid = with_strobe;
        in_data  = 24'h000777;
        step(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 24'd0;
        exp_q.delete();
        tb_cnt = 0;
    endtask

    task automatic drain(input string name);
        int budget;
        logic [23:0] exp;
        budget = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && budget < 200) begin
            if (out_valid) begin
                exp = exp_q.pop_front();
                tests_run++;
                if (out_data !== exp) begin
                    fails++;
                    $display("FAIL %s data: got %h expected %h", name, out_data, exp);
                end
            end
            step(1);
            budget++;
        end
        out_ready = 1'b0;
        tests_run++;
        if (budget >= 200) begin
            fails++;
            $display("FAIL %s drain timeout: %0d entries still expected", name, exp_q.size());
            exp_q.delete();
        end
        tests_run++;
        if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin
            fails++;
            $display("FAIL %s empty after drain: out_valid %b level %0d expected 0 0",
                     name, out_valid, fifo_level);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 24'd0 || fifo_level !== 5'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset state: valid %b data %h level %0d ovf %b expected 0 000000 0 0",
                     out_valid, out_data, fifo_level, overflow);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_format_basic();
        cfg_num_bits = 5'd16; cfg_offset_binary = 1'b0; cfg_decim = 4'd0;
        send(24'h008000);
        check_bit("latency edge1 out_valid", out_valid, 1'b0);
        send(24'h007FFF);
        check_bit("latency edge2 out_valid", out_valid, 1'b1);
        step(1);
        tests_run++;
        if (fifo_level !== 5'd2) begin
            fails++;
            $display("FAIL basic level peak: got %0d expected 2", fifo_level);
        end
        drain("basic");
    endtask

    task automatic test_format_offset();
        cfg_num_bits = 5'd16; cfg_offset_binary = 1'b1;
        send(24'h008000);
        send(24'h000000);
        send(24'hFF1234);
        cfg_num_bits = 5'd0; cfg_offset_binary = 1'b0;
        send(24'h123456);
        cfg_num_bits = 5'd12;
        send(24'hABC801);
        cfg_num_bits = 5'd1; cfg_offset_binary = 1'b1;
        send(24'hFFFFFF);
        step(1);
        drain("offset");
        cfg_num_bits = 5'd24; cfg_offset_binary = 1'b0;
    endtask

    task automatic test_decim();
        cfg_decim = 4'd3;
        for (int i = 1; i <= 8; i++) send(24'(i));
        step(2);
        tests_run++;
        if (fifo_level !== 5'd2) begin
            fails++;
            $display("FAIL decim kept count: got %0d expected 2", fifo_level);
        end
        drain("decim");
        cfg_decim = 4'd0;
    endtask

    task automatic test_overflow();
        logic [23:0] exp;
        for (int i = 0; i <= 16; i++) send(24'(i));
        void'(exp_q.pop_back());
        step(2);
        tests_run++;
        if (fifo_level !== 5'd16 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow full: level %0d ovf %b expected 16 1", fifo_level, overflow);
        end
        drain("overflow");
        check_bit("overflow sticky", overflow, 1'b1);
        pulse_clear(1'b0);
        check_bit("overflow cleared", overflow, 1'b0);
        for (int i = 0; i < 16; i++) send(24'(i));
        step(2);
        in_valid  = 1'b1;
        in_data   = 24'd16;
        out_ready = 1'b1;
        exp = exp_q.pop_front();
        tests_run++;
        if (out_data !== exp) begin
            fails++;
            $display("FAIL full pop head: got %h expected %h", out_data, exp);
        end
        exp_q.push_back(24'd16);
        step(1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step(2);
        tests_run++;
        if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full with pop: level %0d ovf %b expected 16 0", fifo_level, overflow);
        end
        drain("full_pop");
    endtask

    task automatic test_clear();
        for (int i = 0; i < 4; i++) send(24'h0000A0 + 24'(i));
        cfg_decim = 4'd2;
        send(24'h000055);
        step(2);
        tests_run++;
        if (fifo_level !== 5'd5) begin
            fails++;
            $display("FAIL clear prefill level: got %0d expected 5", fifo_level);
        end
        pulse_clear(1'b1);
        tests_run++;
        if (fifo_level !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL clear state: level %0d valid %b ovf %b expected 0 0 0",
                     fifo_level, out_valid, overflow);
        end
        step(1);
        check_bit("clear strobe ignored", out_valid, 1'b0);
        send(24'hABCDEF);
        check_bit("post clear edge1", out_valid, 1'b0);
        step(1);
        check_bit("post clear edge2", out_valid, 1'b1);
        drain("clear");
        cfg_decim = 4'd0;
        pulse_clear(1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 8; i++) send(24'(i * 3));
        step(2);
        tests_run++;
        if (fifo_level !== 5'd8) begin
            fails++;
            $display("FAIL arst prefill level: got %0d expected 8", fifo_level);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 24'd0 || fifo_level !== 5'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL arst immediate: valid %b data %h level %0d ovf %b expected 0 000000 0 0",
                     out_valid, out_data, fifo_level, overflow);
        end
        exp_q.delete();
        tb_cnt = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(24'h3C3C3C);
        check_bit("arst edge1", out_valid, 1'b0);
        step(1);
        check_bit("arst edge2", out_valid, 1'b1);
        drain("arst");
    endtask

    initial begin
        test_reset();
        test_format_basic();
        test_format_offset();
        test_decim();
        test_overflow();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
